apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  APB requester that drives the slave1/slave2 bus from a simple command port.
//  Accepts one read/write command at a time and runs the APB SETUP/ACCESS sequence.
//  Decodes the slave from the command address, waits on that slave's PREADY and returns
//  read data or an error on a one-cycle response strobe. Sits between the system-side
//  controller and the APB slaves.
// PARAMETERS
//  TIMEOUT_CYC   16  max ACCESS cycles with PREADY low before abort (>=1)
//  SLV_AW        6   implemented slave address bits (64-entry slave memory)
// PORTS
//  PCLK       in   1  bus clock, all state on rising edge
//  PRESETn    in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at PCLK edge
//  cmd_write  in   1  1=write, 0=read
//  cmd_addr   in   9  [8]=slave select (0:slave1, 1:slave2), [7:0]=PADDR
//  cmd_wdata  in   8  write data
//  rsp_valid  out  1  one-cycle response strobe
//  rsp_rdata  out  8  read data (0 for writes and errors), valid with rsp_valid
//  rsp_err    out  1  error flag, valid with rsp_valid
//  PSEL1      out  1  select slave1
//  PSEL2      out  1  select slave2
//  PENABLE    out  1  APB access phase
//  PWRITE     out  1  APB direction
//  PADDR      out  8  APB address
//  PWDATA     out  8  APB write data
//  PRDATA1    in   8  slave1 read data
//  PRDATA2    in   8  slave2 read data
//  PREADY1    in   1  slave1 ready
//  PREADY2    in   1  slave2 ready
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; PSEL1/2, PENABLE, PWRITE, PADDR, PWDATA,
//    rsp_valid, rsp_rdata, rsp_err, timeout counter all 0. Reset mid-transfer drops PSEL
//    and PENABLE immediately; no response is issued for the aborted command.
//  - All APB outputs and rsp_* are registered. cmd_ready = (state==IDLE), so it reads 1
//    out of reset.
//  - FSM states: IDLE, SETUP, ACCESS, ERR.
//  - IDLE: on accept, capture write/addr/wdata.
//    - If cmd_addr[7:SLV_AW] != 0 -> go to ERR. No PSEL is asserted.
//    - Otherwise -> SETUP. Drive PSELx=1, PENABLE=0, PADDR, PWRITE, PWDATA.
//  - SETUP: exactly one cycle, then -> ACCESS with PENABLE=1.
//  - ACCESS: PSELx, PADDR, PWRITE and PWDATA are held stable.
//    - Selected PREADY=1 at an edge: drop PSELx/PENABLE and go to IDLE.
//      Next cycle: rsp_valid=1, rsp_err=0; rsp_rdata = selected PRDATA for a read, else 0.
//    - Selected PREADY=0: increment the counter. When it reaches TIMEOUT_CYC: drop
//      PSELx/PENABLE, go to IDLE, and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    - The counter clears on every accept.
//  - ERR: one cycle; rsp_valid=1, rsp_err=1, rsp_rdata=0, then -> IDLE.
//  - Only the decoded slave's PREADY/PRDATA are observed; the unselected slave's are ignored.
//  - PADDR/PWDATA/PWRITE keep their last values in IDLE; PSEL1 and PSEL2 are never both 1.
//  - Latency, zero-wait slave: accept edge T0, SETUP T0+1, ACCESS T0+2, rsp_valid T0+3.
//  - A new command may be accepted in the same cycle rsp_valid is high (state=IDLE).
//  - cmd_valid is ignored outside IDLE. Command fields are sampled only at accept.
// TESTING
//  1. Write 0x005 data 0xA5, then read 0x005.
//     -> PSEL1 only; read rsp_rdata=0xA5, rsp_err=0; rsp_valid 3 cycles after each accept.
//  2. Write 0x13F data 0x5A, then read 0x13F.
//     -> PSEL2 only, PADDR=0x3F; rsp_rdata=0x5A. slave1 memory unchanged.
//  3. Read 0x010 with PREADY1 held low 3 ACCESS cycles.
//     -> PENABLE high 4 cycles, PADDR stable; rsp_valid the cycle after PREADY1=1.
//  4. Read 0x020 with PREADY1 stuck low.
//     -> after 16 ACCESS cycles PSEL1/PENABLE drop; rsp_err=1, rsp_rdata=0. Next command works.
//  5. Command addr 0x040.
//     -> no PSEL asserted; rsp_valid=1, rsp_err=1 one cycle after accept.
//  6. Assert PRESETn=0 mid-ACCESS.
//     -> PSEL/PENABLE 0 asynchronously, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: one command at a time runs SETUP/ACCESS on slave1 or slave2 and returns a one-cycle response.
// Latency: 3 cycles from accept to rsp_valid with a zero-wait slave; cmd_ready is low until the FSM returns to IDLE.
module apb_master #(
    parameter int TIMEOUT_CYC = 16,
    parameter int SLV_AW      = 6
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [8:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    input  logic       PREADY1,
    input  logic       PREADY2
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t         state_q, state_d;
    logic           sel_q, sel_d;
    logic           psel1_q, psel1_d;
    logic           psel2_q, psel2_d;
    logic           penable_q, penable_d;
    logic           pwrite_q, pwrite_d;
    logic [7:0]     paddr_q, paddr_d;
    logic [7:0]     pwdata_q, pwdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           sel_pready;
    logic [7:0]     sel_prdata;
    logic           addr_oob;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 8'd0;

        // Only the slave latched at accept is ever looked at.
        sel_pready  = sel_q ? PREADY2 : PREADY1;
        sel_prdata  = sel_q ? PRDATA2 : PRDATA1;
        addr_oob    = (cmd_addr[7:0] >> SLV_AW) != 8'd0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr[7:0];
                    pwdata_d = cmd_wdata;
                    sel_d    = cmd_addr[8];
                    cnt_d    = '0;
                    if (addr_oob) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        psel1_d = ~cmd_addr[8];
                        psel2_d = cmd_addr[8];
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (sel_pready) begin
                    state_d     = IDLE;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? 8'd0 : sel_prdata;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        state_d     = IDLE;
                        psel1_d     = 1'b0;
                        psel2_d     = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'd0;
            pwdata_q    <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with two 64-byte APB slave models whose PREADY is bench-controlled.
module tb_apb_master;
    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [8:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
    logic       PREADY1, PREADY2;

    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];

    int checks   = 0;
    int failures = 0;

    apb_master #(.TIMEOUT_CYC(16), .SLV_AW(6)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA1 = mem1[PADDR[5:0]];
    assign PRDATA2 = mem2[PADDR[5:0]];

    always @(posedge PCLK) begin
        if (PSEL1 && PENABLE && PWRITE && PREADY1) mem1[PADDR[5:0]] <= PWDATA;
        if (PSEL2 && PENABLE && PWRITE && PREADY2) mem2[PADDR[5:0]] <= PWDATA;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns at the negedge of the SETUP (or ERR) cycle.
    task automatic send(input logic wr, input logic [8:0] addr, input logic [7:0] wd);
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        chk("cmd_ready_idle", cmd_ready, 8'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 9'h1EE; cmd_wdata = 8'hEE;
    endtask

    task automatic txn(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd);
        send(wr, addr, wd);
        chk("setup_psel1", PSEL1, {7'd0, ~addr[8]});
        chk("setup_psel2", PSEL2, {7'd0, addr[8]});
        chk("setup_penable", PENABLE, 8'd0);
        chk("setup_paddr", PADDR, addr[7:0]);
        chk("setup_pwrite", PWRITE, {7'd0, wr});
        if (wr) chk("setup_pwdata", PWDATA, wd);
        chk("setup_cmd_ready", cmd_ready, 8'd0);
        @(negedge PCLK);
        chk("access_penable", PENABLE, 8'd1);
        chk("access_paddr", PADDR, addr[7:0]);
        chk("access_rsp_valid", rsp_valid, 8'd0);
        @(negedge PCLK);
        chk("rsp_valid", rsp_valid, 8'd1);
        chk("rsp_err", rsp_err, 8'd0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_psel", {6'd0, PSEL2, PSEL1}, 8'd0);
        chk("rsp_penable", PENABLE, 8'd0);
        chk("rsp_cmd_ready", cmd_ready, 8'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 8'd0;
            mem2[i] = 8'd0;
        end
        mem1[6'h10] = 8'h3C;
        mem1[6'h20] = 8'h77;
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 9'd0; cmd_wdata = 8'd0;
        PREADY1 = 1'b1; PREADY2 = 1'b1;

        // Reset state
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready, 8'd1);
        chk("rst_psel", {6'd0, PSEL2, PSEL1}, 8'd0);
        chk("rst_penable", PENABLE, 8'd0);
        chk("rst_pwrite", PWRITE, 8'd0);
        chk("rst_paddr", PADDR, 8'd0);
        chk("rst_pwdata", PWDATA, 8'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, 6'd0}, 8'd0);
        chk("rst_rdata", rsp_rdata, 8'd0);
        PRESETn = 1'b1;

        // 1: slave1 write then read back
        txn(1'b1, 9'h005, 8'hA5, 8'h00);
        @(negedge PCLK);
        chk("rsp_valid_one_cycle", rsp_valid, 8'd0);
        txn(1'b0, 9'h005, 8'h00, 8'hA5);

        // 2: slave2 write then read back; slave1 location 0x3F untouched
        txn(1'b1, 9'h13F, 8'h5A, 8'h00);
        txn(1'b0, 9'h13F, 8'h00, 8'h5A);
        chk("slave1_unchanged", mem1[6'h3F], 8'h00);
        chk("slave2_written", mem2[6'h3F], 8'h5A);

        // 3: three wait states on slave1; slave2's PREADY is high but must be ignored
        PREADY1 = 1'b0;
        send(1'b0, 9'h010, 8'h00);
        chk("wait_setup_penable", PENABLE, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("wait_penable", PENABLE, 8'd1);
            chk("wait_psel1", PSEL1, 8'd1);
            chk("wait_paddr", PADDR, 8'h10);
            chk("wait_rsp_valid", rsp_valid, 8'd0);
            if (i == 3) PREADY1 = 1'b1;
        end
        @(negedge PCLK);
        chk("wait_rsp_valid_end", rsp_valid, 8'd1);
        chk("wait_rsp_rdata", rsp_rdata, 8'h3C);
        chk("wait_rsp_err", rsp_err, 8'd0);
        chk("wait_penable_drop", PENABLE, 8'd0);

        // 4: PREADY1 stuck low -> timeout after 16 ACCESS cycles
        PREADY1 = 1'b0;
        send(1'b0, 9'h020, 8'h00);
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            chk("to_penable", PENABLE, 8'd1);
            chk("to_rsp_valid", rsp_valid, 8'd0);
        end
        @(negedge PCLK);
        chk("to_rsp_valid_end", rsp_valid, 8'd1);
        chk("to_rsp_err", rsp_err, 8'd1);
        chk("to_rsp_rdata", rsp_rdata, 8'h00);
        chk("to_psel1_drop", PSEL1, 8'd0);
        chk("to_penable_drop", PENABLE, 8'd0);
        chk("to_cmd_ready", cmd_ready, 8'd1);
        PREADY1 = 1'b1;
        txn(1'b0, 9'h005, 8'h00, 8'hA5);

        // 5: address beyond the implemented slave range
        send(1'b0, 9'h040, 8'h00);
        chk("err_rsp_valid", rsp_valid, 8'd1);
        chk("err_rsp_err", rsp_err, 8'd1);
        chk("err_rsp_rdata", rsp_rdata, 8'h00);
        chk("err_psel", {6'd0, PSEL2, PSEL1}, 8'd0);
        chk("err_cmd_ready", cmd_ready, 8'd0);
        @(negedge PCLK);
        chk("err_rsp_valid_drop", rsp_valid, 8'd0);
        chk("err_cmd_ready_back", cmd_ready, 8'd1);
        chk("err_psel_after", {6'd0, PSEL2, PSEL1}, 8'd0);

        // 6: reset asserted in the middle of an ACCESS phase on slave2
        PREADY2 = 1'b0;
        send(1'b0, 9'h101, 8'h00);
        @(negedge PCLK);
        chk("rst6_penable_before", PENABLE, 8'd1);
        chk("rst6_psel2_before", PSEL2, 8'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst6_psel_async", {6'd0, PSEL2, PSEL1}, 8'd0);
        chk("rst6_penable_async", PENABLE, 8'd0);
        @(negedge PCLK);
        PREADY2 = 1'b1;
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("rst6_no_rsp", rsp_valid, 8'd0);
            chk("rst6_cmd_ready", cmd_ready, 8'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
